ulpi_phy_emu: RTL and testbench

- Synthesizable ULPI PHY emulator; it is the PHY-side counterpart of the link inside `top`.
- Sits on the same 8-bit ULPI bus and answers link traffic: register writes/reads, transmit commands, PHY reset, and RX CMDs on line-state changes.
- Used in FPGA loopback and as the self-checking bus partner in system benches, replacing hand-sequenced DIR/NXT stimulus.

---
 rtl/ulpi_phy_emu.sv | 228 ++++++++++++++++++++++
 tb/tb_ulpi_phy_emu.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_phy_emu.sv
// ULPI PHY emulator: answers link register writes/reads, TX CMDs and PHY reset, and issues RX CMDs on line-state changes.
// Optional build macro ULPI_EMU_LINESTATE_FILTER_EN adds a LINESTATE stability filter of FILTER_CYCLES cycles.
module ulpi_phy_emu #(
    parameter int STARTUP_CYCLES = 8,
    parameter int RESET_CYCLES   = 16,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic       USB_CLKIN,
    input  logic       NRST,
    input  logic [7:0] ULPI_DATA_I,
    output logic [7:0] ULPI_DATA_O,
    output logic       ULPI_DATA_OE,
    output logic       ULPI_DIR,
    output logic       ULPI_NXT,
    input  logic       ULPI_STP,
    input  logic [1:0] LINESTATE,
    input  logic [1:0] VBUS_STATE,
    output logic       TX_ACTIVE,
    output logic [3:0] TX_PID,
    output logic [7:0] TX_BYTE,
    output logic       TX_BYTE_VLD,
    output logic [7:0] REG_FUNC_CTRL,
    output logic [7:0] REG_OTG_CTRL,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] ST_STARTUP   = 4'd0;
    localparam logic [3:0] ST_IDLE      = 4'd1;
    localparam logic [3:0] ST_WR_CMD    = 4'd2;
    localparam logic [3:0] ST_WR_DATA   = 4'd3;
    localparam logic [3:0] ST_WR_STP    = 4'd4;
    localparam logic [3:0] ST_RD_CMD    = 4'd5;
    localparam logic [3:0] ST_RD_TA1    = 4'd6;
    localparam logic [3:0] ST_RD_DATA   = 4'd7;
    localparam logic [3:0] ST_RD_TA2    = 4'd8;
    localparam logic [3:0] ST_TX_CMD    = 4'd9;
    localparam logic [3:0] ST_TX_DATA   = 4'd10;
    localparam logic [3:0] ST_RX_TA1    = 4'd11;
    localparam logic [3:0] ST_RX_DATA   = 4'd12;
    localparam logic [3:0] ST_RX_TA2    = 4'd13;
    localparam logic [3:0] ST_PHY_RESET = 4'd14;

    // One width covers every cycle counter in the block, filter included.
    localparam int MAX_SR  = (STARTUP_CYCLES > RESET_CYCLES) ? STARTUP_CYCLES : RESET_CYCLES;
    localparam int MAX_ALL = (MAX_SR > FILTER_CYCLES) ? MAX_SR : FILTER_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       addr;
    logic [7:0]       wr_data;
    logic [7:0]       dout;
    logic [3:0]       tx_pid;
    logic [7:0]       func_ctrl;
    logic [7:0]       otg_ctrl;
    logic [1:0]       ls_rep;
    logic [1:0]       ls_cur;
    logic [7:0]       func_wr;
    logic [7:0]       otg_wr;
    logic             func_hit;
    logic             otg_hit;
    logic [7:0]       rd_val;
    logic             tx_take;

`ifdef ULPI_EMU_LINESTATE_FILTER_EN
    logic [1:0]       ls_cand;
    logic [1:0]       ls_filt;
    logic [CNT_W-1:0] flt_cnt;
    logic [CNT_W-1:0] flt_nxt;

    // flt_cnt counts consecutive samples equal to ls_cand, saturating at FILTER_CYCLES.
    always_comb begin
        flt_nxt = CNT_W'(1);
        if (LINESTATE == ls_cand) begin
            if (flt_cnt == CNT_W'(FILTER_CYCLES)) flt_nxt = flt_cnt;
            else                                  flt_nxt = flt_cnt + 1'b1;
        end
    end

    always_ff @(posedge USB_CLKIN or negedge NRST) begin
        if (!NRST) begin
            ls_cand <= 2'b00;
            ls_filt <= 2'b00;
            flt_cnt <= '0;
        end else begin
            ls_cand <= LINESTATE;
            flt_cnt <= flt_nxt;
            if (flt_nxt == CNT_W'(FILTER_CYCLES)) ls_filt <= LINESTATE;
        end
    end

    assign ls_cur = ls_filt;
`else
    assign ls_cur = LINESTATE;
`endif

    always_comb begin
        func_wr  = func_ctrl;
        otg_wr   = otg_ctrl;
        func_hit = 1'b0;
        otg_hit  = 1'b0;
        case (addr)
            6'h04: begin func_wr = wr_data;              func_hit = 1'b1; end
            6'h05: begin func_wr = func_ctrl | wr_data;  func_hit = 1'b1; end
            6'h06: begin func_wr = func_ctrl & ~wr_data; func_hit = 1'b1; end
            6'h0A: begin otg_wr  = wr_data;              otg_hit  = 1'b1; end
            6'h0B: begin otg_wr  = otg_ctrl | wr_data;   otg_hit  = 1'b1; end
            6'h0C: begin otg_wr  = otg_ctrl & ~wr_data;  otg_hit  = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        rd_val = 8'h00;
        case (addr)
            6'h04, 6'h05, 6'h06: rd_val = func_ctrl;
            6'h0A, 6'h0B, 6'h0C: rd_val = otg_ctrl;
            default: ;
        endcase
    end

    always_ff @(posedge USB_CLKIN or negedge NRST) begin
        if (!NRST) begin
            state     <= ST_STARTUP;
            cnt       <= '0;
            addr      <= '0;
            wr_data   <= 8'h00;
            dout      <= 8'h00;
            tx_pid    <= 4'h0;
            func_ctrl <= 8'h41;
            otg_ctrl  <= 8'h06;
            ls_rep    <= 2'b00;
        end else begin
            case (state)
                ST_STARTUP: begin
                    // Track the line during startup so the first RX CMD reports a real change.
                    ls_rep <= ls_cur;
                    if (cnt == CNT_W'(STARTUP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (ULPI_DATA_I != 8'h00) begin
                        addr <= ULPI_DATA_I[5:0];
                        case (ULPI_DATA_I[7:6])
                            2'b10: state <= ST_WR_CMD;
                            2'b11: state <= ST_RD_CMD;
                            2'b01: begin
                                tx_pid <= ULPI_DATA_I[3:0];
                                state  <= ST_TX_CMD;
                            end
                            default: ;
                        endcase
                    end else if (ls_cur != ls_rep) begin
                        ls_rep <= ls_cur;
                        dout   <= {4'b0001, VBUS_STATE, ls_cur};
                        state  <= ST_RX_TA1;
                    end
                end
                ST_WR_CMD:  state <= ST_WR_DATA;
                ST_WR_DATA: begin
                    wr_data <= ULPI_DATA_I;
                    state   <= ST_WR_STP;
                end
                ST_WR_STP: begin
                    if (ULPI_STP) begin
                        if (func_hit) func_ctrl <= func_wr;
                        if (otg_hit)  otg_ctrl  <= otg_wr;
                        if (func_hit && func_wr[5]) begin
                            cnt   <= '0;
                            state <= ST_PHY_RESET;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RD_CMD: state <= ST_RD_TA1;
                ST_RD_TA1: begin
                    dout  <= rd_val;
                    state <= ST_RD_DATA;
                end
                ST_RD_DATA: state <= ST_RD_TA2;
                ST_RD_TA2:  state <= ST_IDLE;
                ST_TX_CMD:  state <= ULPI_STP ? ST_IDLE : ST_TX_DATA;
                ST_TX_DATA: if (ULPI_STP) state <= ST_IDLE;
                ST_RX_TA1:  state <= ST_RX_DATA;
                ST_RX_DATA: state <= ST_RX_TA2;
                ST_RX_TA2:  state <= ST_IDLE;
                ST_PHY_RESET: begin
                    if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                        cnt       <= '0;
                        func_ctrl <= func_ctrl & ~8'h20;
                        otg_ctrl  <= 8'h06;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data-phase NXT and the byte strobe follow STP within the same cycle.
    assign tx_take = (state == ST_TX_DATA) && !ULPI_STP;

    always_comb begin
        ULPI_DIR     = (state == ST_STARTUP) || (state == ST_PHY_RESET) ||
                       (state == ST_RD_TA1)  || (state == ST_RD_DATA)   ||
                       (state == ST_RX_TA1)  || (state == ST_RX_DATA);
        ULPI_DATA_OE = (state == ST_RD_DATA) || (state == ST_RX_DATA);
        ULPI_DATA_O  = ULPI_DATA_OE ? dout : 8'h00;
        ULPI_NXT     = (state == ST_WR_CMD) || (state == ST_WR_DATA) ||
                       (state == ST_RD_CMD) || (state == ST_TX_CMD)  || tx_take;
        TX_ACTIVE    = (state == ST_TX_CMD) || (state == ST_TX_DATA);
        TX_BYTE_VLD  = tx_take;
        TX_BYTE      = tx_take ? ULPI_DATA_I : 8'h00;
    end

    assign TX_PID        = tx_pid;
    assign REG_FUNC_CTRL = func_ctrl;
    assign REG_OTG_CTRL  = otg_ctrl;
    assign state_dbg     = state;

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// Directed bench for ulpi_phy_emu: register table, PHY reset, RX CMD, transmit and async-reset sequences.
module tb_ulpi_phy_emu;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] data_i;
    logic       stp;
    logic [1:0] linestate;
    logic [1:0] vbus;
    logic [7:0] data_o;
    logic       oe;
    logic       dir;
    logic       nxt;
    logic       tx_active;
    logic [3:0] tx_pid;
    logic [7:0] tx_byte;
    logic       tx_vld;
    logic [7:0] func_ctrl;
    logic [7:0] otg_ctrl;
    logic [3:0] state_dbg;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

`ifdef ULPI_EMU_LINESTATE_FILTER_EN
    localparam int RX_LAT = 5;
`else
    localparam int RX_LAT = 1;
`endif

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] exp_func;
        logic [7:0] exp_otg;
        logic [7:0] exp_rd;
    } reg_vec_t;

    reg_vec_t vecs[13];

    ulpi_phy_emu dut (
        .USB_CLKIN     (clk),
        .NRST          (nrst),
        .ULPI_DATA_I   (data_i),
        .ULPI_DATA_O   (data_o),
        .ULPI_DATA_OE  (oe),
        .ULPI_DIR      (dir),
        .ULPI_NXT      (nxt),
        .ULPI_STP      (stp),
        .LINESTATE     (linestate),
        .VBUS_STATE    (vbus),
        .TX_ACTIVE     (tx_active),
        .TX_PID        (tx_pid),
        .TX_BYTE       (tx_byte),
        .TX_BYTE_VLD   (tx_vld),
        .REG_FUNC_CTRL (func_ctrl),
        .REG_OTG_CTRL  (otg_ctrl),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive one bus cycle just after the rising edge, return at mid-cycle for sampling.
    task automatic step(input logic [7:0] d, input logic s);
        @(posedge clk);
        #1;
        data_i = d;
        stp    = s;
        @(negedge clk);
    endtask

    task automatic count_dir(input string name, input int exp_n);
        int n = 0;
        while (dir === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(name, 8'(n), 8'(exp_n));
    endtask

    task automatic reg_write(input logic [7:0] cmd, input logic [7:0] d);
        step(cmd, 1'b0);
        chk1("wr_c0_nxt", nxt, 1'b0);
        step(cmd, 1'b0);
        chk1("wr_c1_nxt", nxt, 1'b1);
        chk1("wr_c1_dir", dir, 1'b0);
        step(d, 1'b0);
        chk1("wr_c2_nxt", nxt, 1'b1);
        step(8'h00, 1'b1);
        chk1("wr_c3_nxt", nxt, 1'b0);
        step(8'h00, 1'b0);
    endtask

    task automatic reg_read(input logic [7:0] cmd, input logic [7:0] exp);
        step(cmd, 1'b0);
        step(cmd, 1'b0);
        chk1("rd_c1_nxt", nxt, 1'b1);
        chk1("rd_c1_dir", dir, 1'b0);
        step(8'h00, 1'b0);
        chk1("rd_ta1_dir", dir, 1'b1);
        chk1("rd_ta1_oe", oe, 1'b0);
        step(8'h00, 1'b0);
        chk1("rd_data_dir", dir, 1'b1);
        chk1("rd_data_oe", oe, 1'b1);
        chk("rd_data", data_o, exp);
        step(8'h00, 1'b0);
        chk1("rd_ta2_dir", dir, 1'b0);
        chk1("rd_ta2_oe", oe, 1'b0);
    endtask

    // exp_lat < 0 skips the latency check.
    task automatic expect_rx(input string name, input logic [7:0] exp_byte, input int exp_lat);
        int n = 0;
        while (dir !== 1'b1 && n < 40) begin
            step(8'h00, 1'b0);
            n++;
        end
        if (dir !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: DIR never rose within %0d cycles", name, n);
            return;
        end
        if (exp_lat >= 0) chk({name, "_latency"}, 8'(n), 8'(exp_lat));
        chk1({name, "_ta1_oe"}, oe, 1'b0);
        step(8'h00, 1'b0);
        chk1({name, "_dir"}, dir, 1'b1);
        chk1({name, "_oe"}, oe, 1'b1);
        chk({name, "_byte"}, data_o, exp_byte);
        step(8'h00, 1'b0);
        chk1({name, "_ta2_dir"}, dir, 1'b0);
        chk1({name, "_ta2_oe"}, oe, 1'b0);
    endtask

    task automatic tx_burst(input logic [7:0] cmd, input int nbytes, input logic [7:0] base,
                            input logic [7:0] incr);
        int pulses = 0;
        logic [7:0] b;
        exp_q.delete();
        step(cmd, 1'b0);
        step(cmd, 1'b0);
        chk1("tx_c1_nxt", nxt, 1'b1);
        chk1("tx_c1_active", tx_active, 1'b1);
        chk1("tx_c1_vld", tx_vld, 1'b0);
        chk("tx_pid", {4'h0, tx_pid}, {4'h0, cmd[3:0]});
        for (int i = 0; i < nbytes; i++) begin
            b = base + 8'(i) * incr;
            exp_q.push_back(b);
            step(b, 1'b0);
            chk1("tx_data_nxt", nxt, 1'b1);
            chk1("tx_data_vld", tx_vld, 1'b1);
            if (tx_vld === 1'b1 && exp_q.size() != 0) begin
                pulses++;
                chk("tx_byte", tx_byte, exp_q.pop_front());
            end
        end
        step(8'h00, 1'b1);
        chk1("tx_stp_nxt", nxt, 1'b0);
        chk1("tx_stp_vld", tx_vld, 1'b0);
        chk1("tx_stp_active", tx_active, 1'b1);
        step(8'h00, 1'b0);
        chk1("tx_end_active", tx_active, 1'b0);
        chk("tx_pulses", 8'(pulses), 8'(nbytes));
        chk("tx_queue_left", 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        int highs;

        vecs[0]  = '{8'h8A, 8'h00, 8'h41, 8'h00, 8'h00};
        vecs[1]  = '{8'hCA, 8'h00, 8'h41, 8'h00, 8'h00};
        vecs[2]  = '{8'h84, 8'h55, 8'h55, 8'h00, 8'h00};
        vecs[3]  = '{8'hC4, 8'h00, 8'h55, 8'h00, 8'h55};
        vecs[4]  = '{8'h86, 8'h14, 8'h41, 8'h00, 8'h00};
        vecs[5]  = '{8'h85, 8'h02, 8'h43, 8'h00, 8'h00};
        vecs[6]  = '{8'h8B, 8'h81, 8'h43, 8'h81, 8'h00};
        vecs[7]  = '{8'h8C, 8'h01, 8'h43, 8'h80, 8'h00};
        vecs[8]  = '{8'hCC, 8'h00, 8'h43, 8'h80, 8'h80};
        vecs[9]  = '{8'hC5, 8'h00, 8'h43, 8'h80, 8'h43};
        vecs[10] = '{8'h90, 8'hFF, 8'h43, 8'h80, 8'h00};
        vecs[11] = '{8'hD0, 8'h00, 8'h43, 8'h80, 8'h00};
        vecs[12] = '{8'hC6, 8'h00, 8'h43, 8'h80, 8'h43};

        nrst      = 1'b0;
        data_i    = 8'h00;
        stp       = 1'b0;
        linestate = 2'b01;
        vbus      = 2'b01;

        // Reset values
        @(negedge clk);
        chk1("rst_dir", dir, 1'b1);
        chk1("rst_nxt", nxt, 1'b0);
        chk1("rst_oe", oe, 1'b0);
        chk("rst_data_o", data_o, 8'h00);
        chk1("rst_tx_active", tx_active, 1'b0);
        chk("rst_tx_pid", {4'h0, tx_pid}, 8'h00);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk1("rst_tx_vld", tx_vld, 1'b0);
        chk("rst_func", func_ctrl, 8'h41);
        chk("rst_otg", otg_ctrl, 8'h06);

        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        count_dir("startup_dir_cycles", 8);
        chk("startup_func", func_ctrl, 8'h41);
        chk("startup_otg", otg_ctrl, 8'h06);

        // Register table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].cmd[7:6] == 2'b10) reg_write(vecs[i].cmd, vecs[i].data);
            else                           reg_read(vecs[i].cmd, vecs[i].exp_rd);
            chk("tbl_func", func_ctrl, vecs[i].exp_func);
            chk("tbl_otg", otg_ctrl, vecs[i].exp_otg);
        end

        // FUNC_CTRL.Reset write
        step(8'h84, 1'b0);
        step(8'h84, 1'b0);
        step(8'h65, 1'b0);
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);
        chk("phyrst_func_during", func_ctrl, 8'h65);
        chk1("phyrst_oe", oe, 1'b0);
        count_dir("phyrst_dir_cycles", 16);
        chk("phyrst_func_after", func_ctrl, 8'h45);
        chk("phyrst_otg_after", otg_ctrl, 8'h06);

        // RX CMD on LINESTATE 01 -> 00, VBUS 01
        linestate = 2'b00;
        expect_rx("rx_simple", 8'h14, RX_LAT);

        // Change during a register write is held until after STP
        step(8'h84, 1'b0);
        linestate = 2'b10;
        step(8'h84, 1'b0);
        chk1("defer_c1_dir", dir, 1'b0);
        step(8'h45, 1'b0);
        chk1("defer_c2_dir", dir, 1'b0);
        step(8'h00, 1'b1);
        chk1("defer_c3_dir", dir, 1'b0);
        chk1("defer_c3_nxt", nxt, 1'b0);
        step(8'h00, 1'b0);
        chk("defer_func", func_ctrl, 8'h45);
        expect_rx("rx_deferred", 8'h16, -1);

        // Link command and line change in the same cycle: command first
        linestate = 2'b00;
        reg_read(8'hCA, 8'h06);
        expect_rx("rx_after_cmd", 8'h14, -1);

        // STP and NOOP in IDLE
        step(8'h00, 1'b1);
        chk1("idle_stp_nxt", nxt, 1'b0);
        chk1("idle_stp_dir", dir, 1'b0);
        step(8'h2A, 1'b0);
        step(8'h00, 1'b0);
        chk1("noop_nxt", nxt, 1'b0);
        chk1("noop_dir", dir, 1'b0);

        // Transmit
        tx_burst(8'h40, 5, 8'h00, 8'h00);
        tx_burst(8'h4B, 4, 8'h3C, 8'h51);
        tx_burst(8'h43, 0, 8'h00, 8'h00);

`ifdef ULPI_EMU_LINESTATE_FILTER_EN
        // Two-cycle glitch must not reach the link
        linestate = 2'b11;
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        linestate = 2'b00;
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            step(8'h00, 1'b0);
            if (dir === 1'b1) highs++;
        end
        chk("glitch_dir_cycles", 8'(highs), 8'd0);
`else
        highs = 0;
`endif

        // NRST mid-transaction
        step(8'h45, 1'b0);
        step(8'h45, 1'b0);
        step(8'h11, 1'b0);
        #2;
        nrst   = 1'b0;
        data_i = 8'h00;
        #1;
        chk1("abort_dir", dir, 1'b1);
        chk1("abort_tx_active", tx_active, 1'b0);
        chk1("abort_nxt", nxt, 1'b0);
        chk("abort_func", func_ctrl, 8'h41);
        chk("abort_otg", otg_ctrl, 8'h06);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        count_dir("abort_startup_cycles", 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
